// File: rtl/mul_ctrl.sv
// Control FSM for the 16-bit repeated-addition multiplier (A reg, B down-counter, P reg).
// Optional watchdog abort is compiled in with `define MUL_CTRL_WDOG_EN.
//
// state  | meaning
// IDLE   | waiting for start, all strobes low
// LOAD_A | A register captures din
// LOAD_B | B counter captures din, product cleared, iter_cnt cleared
// ADD    | P <= P + A and B-- while B != 0
// DONE   | one-cycle product-valid pulse
// ERR    | watchdog abort, parked until start (watchdog builds only)
module mul_ctrl #(
    parameter logic [15:0] MAX_ITER = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        eqz,
    output logic        ldA,
    output logic        ldB,
    output logic        clrP,
    output logic        ldP,
    output logic        decB,
    output logic        busy,
    output logic        done,
    output logic [15:0] iter_cnt,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        ADD,
        DONE
`ifdef MUL_CTRL_WDOG_EN
        , ERR
`endif
    } state_t;

    state_t state, next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    // Saturating guard keeps the count from wrapping even if eqz never arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                iter_cnt <= 16'd0;
        else if (state == LOAD_B)               iter_cnt <= 16'd0;
        else if (ldP && (iter_cnt != 16'hFFFF)) iter_cnt <= iter_cnt + 16'd1;
    end

    always_comb begin
        next = state;
        ldA  = 1'b0;
        ldB  = 1'b0;
        clrP = 1'b0;
        ldP  = 1'b0;
        decB = 1'b0;
        busy = 1'b0;
        done = 1'b0;
`ifdef MUL_CTRL_WDOG_EN
        err  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) next = LOAD_A;
            end
            LOAD_A: begin
                ldA  = 1'b1;
                busy = 1'b1;
                next = LOAD_B;
            end
            LOAD_B: begin
                ldB  = 1'b1;
                clrP = 1'b1;
                busy = 1'b1;
                next = ADD;
            end
            ADD: begin
                busy = 1'b1;
                if (eqz) begin
                    next = DONE;
                end
`ifdef MUL_CTRL_WDOG_EN
                else if (iter_cnt == MAX_ITER) begin
                    next = ERR;
                end
`endif
                else begin
                    ldP  = 1'b1;
                    decB = 1'b1;
                end
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
                next = IDLE;
            end
`ifdef MUL_CTRL_WDOG_EN
            ERR: begin
                busy = 1'b1;
                err  = 1'b1;
                if (start) next = IDLE;
            end
`endif
            default: next = IDLE;
        endcase
    end

`ifndef MUL_CTRL_WDOG_EN
    assign err = 1'b0;

    logic unused_max_iter;
    assign unused_max_iter = ^MAX_ITER;
`endif

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl with a small behavioural datapath (A, B counter, P).
// Watchdog vectors run only when MUL_CTRL_WDOG_EN is defined.
module tb_mul_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        eqz;
    logic        ldA, ldB, clrP, ldP, decB, busy, done, err;
    logic [15:0] iter_cnt;

    logic [15:0] a_op, b_op, din;
    logic [15:0] a_reg, b_reg, p_reg;

    int n_chk  = 0;
    int n_pass = 0;

    int c_lda, c_ldb, c_clrp, c_ldp_first, c_ldp_last, n_ldp;
    int c_done, c_done2, n_done, busy_gap;
    logic [63:0] idle_at;

    mul_ctrl #(.MAX_ITER(16'd4)) dut (
        .clk(clk), .rst(rst), .start(start), .eqz(eqz),
        .ldA(ldA), .ldB(ldB), .clrP(clrP), .ldP(ldP), .decB(decB),
        .busy(busy), .done(done), .iter_cnt(iter_cnt), .err(err)
    );

    always #5 clk = ~clk;

    assign din = ldA ? a_op : b_op;
    assign eqz = (b_reg == 16'd0);

    initial begin
        a_reg = 16'd0;
        b_reg = 16'd0;
        p_reg = 16'd0;
    end

    always @(posedge clk) begin
        if (ldA)  a_reg <= din;
        if (ldB)  b_reg <= din;
        else if (decB) b_reg <= b_reg - 16'd1;
        if (clrP) p_reg <= 16'd0;
        else if (ldP) p_reg <= p_reg + a_reg;
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_chk++;
        if (obs == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    endtask

    // Cycle 0 is the cycle in which start is first sampled high.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold,
                          input int sp1, input int sp2, input int rst_cyc, input int budget);
        c_lda = -1; c_ldb = -1; c_clrp = -1; c_ldp_first = -1; c_ldp_last = -1;
        c_done = -1; c_done2 = -1; n_ldp = 0; n_done = 0; busy_gap = 0; idle_at = '0;
        @(negedge clk);
        a_op = a; b_op = b; start = 1'b1;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(posedge clk);
            #1;
            start = (cyc < hold) || (cyc == sp1) || (cyc == sp2);
            if (ldA  && c_lda  < 0) c_lda  = cyc;
            if (ldB  && c_ldb  < 0) c_ldb  = cyc;
            if (clrP && c_clrp < 0) c_clrp = cyc;
            if (ldP) begin
                if (c_ldp_first < 0) c_ldp_first = cyc;
                c_ldp_last = cyc;
                n_ldp++;
            end
            if (done) begin
                if (c_done < 0) c_done = cyc;
                else if (c_done2 < 0) c_done2 = cyc;
                n_done++;
            end
            if (!busy && n_done == 0) busy_gap++;
            if (cyc < 64) idle_at[cyc] = !busy;
            if (cyc == rst_cyc) begin
                chk("rst_pre_busy", busy, 1);
                rst = 1'b1;
                #1;
                chk("rst_async_ldP", ldP, 0);
                chk("rst_async_decB", decB, 0);
                chk("rst_async_busy", busy, 0);
                chk("rst_async_iter", iter_cnt, 0);
                @(negedge clk);
                rst = 1'b0;
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && busy; i++) @(posedge clk);
        #1;
        chk("drain_idle", busy, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a_op = '0; b_op = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_strobes", {ldA, ldB, clrP, ldP, decB, done}, 0);
        chk("reset_iter", iter_cnt, 0);
        chk("reset_err", err, 0);
        @(negedge clk);
        rst = 1'b0;

        // A=7, B=3
        run_op(16'd7, 16'd3, 1, -1, -1, -1, 10);
        chk("a7b3_ldA_cyc", c_lda, 1);
        chk("a7b3_ldB_cyc", c_ldb, 2);
        chk("a7b3_clrP_cyc", c_clrp, 2);
        chk("a7b3_ldP_first", c_ldp_first, 3);
        chk("a7b3_ldP_last", c_ldp_last, 5);
        chk("a7b3_ldP_n", n_ldp, 3);
        chk("a7b3_done_cyc", c_done, 7);
        chk("a7b3_iter", iter_cnt, 3);
        chk("a7b3_prod", p_reg, 21);
        chk("a7b3_idle8", idle_at[8], 1);

        // B=0: no additions
        run_op(16'h1234, 16'd0, 1, -1, -1, -1, 8);
        chk("b0_ldP_n", n_ldp, 0);
        chk("b0_done_cyc", c_done, 4);
        chk("b0_iter", iter_cnt, 0);
        chk("b0_prod", p_reg, 0);

        // start pulses mid-operation are ignored
        run_op(16'd4, 16'd3, 1, 2, 5, -1, 12);
        chk("ign_done_n", n_done, 1);
        chk("ign_done_cyc", c_done, 7);
        chk("ign_busy_gap", busy_gap, 0);
        chk("ign_prod", p_reg, 12);
        drain();

        // start held for 20 cycles, B=1: back-to-back
        run_op(16'd3, 16'd1, 20, -1, -1, -1, 20);
        chk("b2b_done1", c_done, 5);
        chk("b2b_done2", c_done2, 11);
        chk("b2b_idle6", idle_at[6], 1);
        chk("b2b_idle12", idle_at[12], 1);
        chk("b2b_done_n", n_done, 3);
        drain();
        chk("b2b_prod", p_reg, 3);

        // reset during ADD, then a normal run
        run_op(16'd5, 16'd10, 1, -1, -1, 6, 8);
        chk("rst_no_done", n_done, 0);
        run_op(16'd5, 16'd2, 1, -1, -1, -1, 8);
        chk("after_rst_done", c_done, 6);
        chk("after_rst_iter", iter_cnt, 2);
        chk("after_rst_prod", p_reg, 10);
        chk("after_rst_err", err, 0);

`ifdef MUL_CTRL_WDOG_EN
        // watchdog: MAX_ITER=4, B=10
        run_op(16'd2, 16'd10, 1, -1, -1, -1, 12);
        chk("wd_ldP_n", n_ldp, 4);
        chk("wd_done_n", n_done, 0);
        chk("wd_err", err, 1);
        chk("wd_busy", busy, 1);
        chk("wd_iter", iter_cnt, 4);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("wd_err_clear", err, 0);
        chk("wd_exit_idle", busy, 0);
        run_op(16'd6, 16'd2, 1, -1, -1, -1, 8);
        chk("wd_next_prod", p_reg, 12);
        chk("wd_next_done", c_done, 6);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
